// File: rtl/r2sdf_twiddle_gen.sv
// r2sdf_twiddle_gen
// Pipelined twiddle-factor generator for R2SDF FFT butterflies.
// Produces W = cos(2*pi*k/N) -/+ j*sin(2*pi*k/N) from a single quarter-wave
// sine table of N/4+1 words. Both the real and imaginary parts come from the
// same table through two read ports.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous reset, active-high (dominates ce)
//   ce        pipeline advance enable; all state holds while low
//   in_vld    request valid, sampled only when ce=1
//   in_idx    base index (LOG2N-1 bits)
//   in_shift  stage shift, k = (in_idx << in_shift) mod N/2
//   in_inv    0: forward (wi = -sin), 1: inverse (wi = +sin)
//   out_vld   result valid, three ce-cycles after the request
//   out_wr    real part (cos), signed DW bits
//   out_wi    imaginary part (-/+sin), signed DW bits
module r2sdf_twiddle_gen #(
    parameter  int DW    = 16,
    parameter  int LOG2N = 8,
    localparam int SW    = $clog2(LOG2N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic                 in_vld,
    input  logic [LOG2N-2:0]     in_idx,
    input  logic [SW-1:0]        in_shift,
    input  logic                 in_inv,
    output logic                 out_vld,
    output logic signed [DW-1:0] out_wr,
    output logic signed [DW-1:0] out_wi
);

    localparam int KW   = LOG2N - 1;          // width of k, range [0, N/2)
    localparam int NQ   = 2 ** (LOG2N - 2);   // quarter period q = N/4
    localparam int MAXV = 2 ** (DW - 1) - 1;  // full-scale magnitude
    localparam logic [KW-1:0] Q_K = KW'(NQ);

    // Rounded sine word S[m] = round(sin(2*pi*m/N) * MAX). The argument never
    // exceeds pi/2, so a short Taylor series is far below 1 LSB of error.
    function automatic logic [DW-1:0] sin_word(input int m);
        real x;
        real term;
        real acc;
        x    = 6.283185307179586 * real'(m) / real'(2 ** LOG2N);
        acc  = x;
        term = x;
        for (int i = 1; i < 12; i++) begin
            term = -term * x * x / real'((2 * i) * (2 * i + 1));
            acc  = acc + term;
        end
        return DW'($rtoi(acc * real'(MAXV) + 0.5));
    endfunction

    // Quarter-wave table, entries 0..N/4, all non-negative.
    logic [DW-1:0] sin_tab [0:NQ];

    for (genvar g = 0; g <= NQ; g++) begin : g_tab
        assign sin_tab[g] = sin_word(g);
    end

    // Stage 1 state
    logic [KW-1:0] cos_addr_q, cos_addr_d;
    logic [KW-1:0] sin_addr_q, sin_addr_d;
    logic          fold1_q, fold1_d;
    logic          inv1_q, inv1_d;
    logic          vld1_q, vld1_d;
    // Stage 2 state
    logic [DW-1:0] rd_cos_q, rd_cos_d;
    logic [DW-1:0] rd_sin_q, rd_sin_d;
    logic          fold2_q, fold2_d;
    logic          inv2_q, inv2_d;
    logic          vld2_q, vld2_d;
    // Stage 3 (output) state
    logic          out_vld_q, out_vld_d;
    logic [DW-1:0] out_wr_q, out_wr_d;
    logic [DW-1:0] out_wi_q, out_wi_d;

    // Stage 1 combinational helpers
    logic [KW-1:0] k_s;
    logic          fold_s;
    logic [KW-1:0] cos_addr_s;
    logic [KW-1:0] sin_addr_s;
    // Stage 3 combinational helpers
    logic [DW-1:0] cos_sgn_s;
    logic [DW-1:0] sin_sgn_s;

    // Stage 1: index scaling and quarter-wave folding into two table addresses.
    always_comb begin
        // Shift is evaluated at KW bits, so bits past the top are discarded
        // and any shift >= KW yields k = 0.
        k_s    = in_idx << in_shift;
        fold_s = (k_s > Q_K);
        if (fold_s) begin
            cos_addr_s = k_s - Q_K;
            // N/2 - k, computed modulo 2**KW = N/2
            sin_addr_s = {KW{1'b0}} - k_s;
        end else begin
            cos_addr_s = Q_K - k_s;
            sin_addr_s = k_s;
        end
        if (ce) begin
            cos_addr_d = cos_addr_s;
            sin_addr_d = sin_addr_s;
            fold1_d    = fold_s;
            inv1_d     = in_inv;
            vld1_d     = in_vld;
        end else begin
            cos_addr_d = cos_addr_q;
            sin_addr_d = sin_addr_q;
            fold1_d    = fold1_q;
            inv1_d     = inv1_q;
            vld1_d     = vld1_q;
        end
    end

    // Stage 2: registered dual-port table read, side-band flags follow along.
    always_comb begin
        if (ce) begin
            rd_cos_d = sin_tab[cos_addr_q];
            rd_sin_d = sin_tab[sin_addr_q];
            fold2_d  = fold1_q;
            inv2_d   = inv1_q;
            vld2_d   = vld1_q;
        end else begin
            rd_cos_d = rd_cos_q;
            rd_sin_d = rd_sin_q;
            fold2_d  = fold2_q;
            inv2_d   = inv2_q;
            vld2_d   = vld2_q;
        end
    end

    // Stage 3: sign application; data registers only load on valid slots.
    always_comb begin
        // Table words are non-negative, so negation cannot overflow.
        if (fold2_q) begin
            cos_sgn_s = {DW{1'b0}} - rd_cos_q;
        end else begin
            cos_sgn_s = rd_cos_q;
        end
        if (inv2_q) begin
            sin_sgn_s = rd_sin_q;
        end else begin
            sin_sgn_s = {DW{1'b0}} - rd_sin_q;
        end
        if (ce) begin
            out_vld_d = vld2_q;
            if (vld2_q) begin
                out_wr_d = cos_sgn_s;
                out_wi_d = sin_sgn_s;
            end else begin
                out_wr_d = out_wr_q;
                out_wi_d = out_wi_q;
            end
        end else begin
            out_vld_d = out_vld_q;
            out_wr_d  = out_wr_q;
            out_wi_d  = out_wi_q;
        end
    end

    // Pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cos_addr_q <= {KW{1'b0}};
            sin_addr_q <= {KW{1'b0}};
            fold1_q    <= 1'b0;
            inv1_q     <= 1'b0;
            vld1_q     <= 1'b0;
            rd_cos_q   <= {DW{1'b0}};
            rd_sin_q   <= {DW{1'b0}};
            fold2_q    <= 1'b0;
            inv2_q     <= 1'b0;
            vld2_q     <= 1'b0;
            out_vld_q  <= 1'b0;
            out_wr_q   <= {DW{1'b0}};
            out_wi_q   <= {DW{1'b0}};
        end else begin
            cos_addr_q <= cos_addr_d;
            sin_addr_q <= sin_addr_d;
            fold1_q    <= fold1_d;
            inv1_q     <= inv1_d;
            vld1_q     <= vld1_d;
            rd_cos_q   <= rd_cos_d;
            rd_sin_q   <= rd_sin_d;
            fold2_q    <= fold2_d;
            inv2_q     <= inv2_d;
            vld2_q     <= vld2_d;
            out_vld_q  <= out_vld_d;
            out_wr_q   <= out_wr_d;
            out_wi_q   <= out_wi_d;
        end
    end

    assign out_vld = out_vld_q;
    assign out_wr  = out_wr_q;
    assign out_wi  = out_wi_q;

endmodule
